dmem_arbiter: RTL and testbench

- Shares the single-port, synchronous-read data memory (D_memory) between two requesters.
- Port A is the CPU MEM stage (load/store). Port B is the debug/DMA loader.
- Arbitrates per cycle, drives the memory address/data/write-enable, and routes the one-cycle-late read data back to the requester that issued the read.
- Port A has fixed priority, with an anti-starvation override for port B.

---
 rtl/dmem_arbiter_pkg.sv | 34 +++
 rtl/dmem_arbiter.sv | 97 +++++++++
 tb/tb_dmem_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and types for the data-memory arbiter.
// Mirrors the global memory sizing and the read-owner encodings used by the core.
package dmem_arbiter_pkg;

  localparam int DMEM_DSIZE     = 16;  // data word width
  localparam int DMEM_MEM_SPACE = 8;   // data memory address width
  localparam int ARB_MAX_WAIT   = 4;   // denials tolerated before port B is forced in

  // Which port owns the read data coming back from the memory this cycle.
  typedef enum logic [1:0] {
    ARB_NONE = 2'd0,
    ARB_A    = 2'd1,
    ARB_B    = 2'd2
  } rd_owner_t;

  // Owner of next cycle's read data, given this cycle's grants.
  // Grants are mutually exclusive, so at most one branch can apply.
  function automatic rd_owner_t next_rd_owner(
    input logic a_gnt,
    input logic a_we,
    input logic b_gnt,
    input logic b_we
  );
    rd_owner_t owner;
    owner = ARB_NONE;
    if (a_gnt && !a_we) begin
      owner = ARB_A;
    end else if (b_gnt && !b_we) begin
      owner = ARB_B;
    end
    return owner;
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port, synchronous-read data memory.
// Port A (CPU MEM stage) has fixed priority; port B (debug/DMA loader) is
// forced through after MAX_WAIT consecutive denials. Read data returns one
// cycle after the grant and is steered to the requester that issued the read.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DSIZE    = DMEM_DSIZE,
  parameter int ADDR_W   = DMEM_MEM_SPACE,
  parameter int MAX_WAIT = ARB_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst,        // asynchronous, active low

  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DSIZE-1:0]  a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DSIZE-1:0]  a_rdata,

  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DSIZE-1:0]  b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DSIZE-1:0]  b_rdata,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [DSIZE-1:0]  mem_wdata,
  output logic              mem_we,
  input  logic [DSIZE-1:0]  mem_rdata,

  output logic              b_starved
);

  // Counter must be able to hold MAX_WAIT itself (saturation value).
  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] b_wait_cnt_reg;
  rd_owner_t        rd_owner_reg;
  logic             force_b;

  // Per-cycle grant decision: A wins unless B has waited long enough.
  always_comb begin
    force_b   = (b_wait_cnt_reg == MAX_CNT);
    b_gnt     = b_req & (~a_req | force_b);
    a_gnt     = a_req & ~b_gnt;
    b_starved = force_b & b_req;
  end

  // Steer the granted port onto the memory; idle cycles become a harmless read of a_addr.
  always_comb begin
    mem_addr  = a_addr;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (b_gnt) begin
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
      mem_we    = b_we;
    end else if (a_gnt) begin
      mem_addr  = a_addr;
      mem_wdata = a_wdata;
      mem_we    = a_we;
    end
  end

  // Count consecutive denials of a requesting port B, saturating at MAX_WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_wait_cnt_reg <= '0;
    end else if (!b_req || b_gnt) begin
      b_wait_cnt_reg <= '0;
    end else if (b_wait_cnt_reg != MAX_CNT) begin
      b_wait_cnt_reg <= b_wait_cnt_reg + 1'b1;
    end
  end

  // Read-return FSM: remember who issued this cycle's read so next cycle's data goes back to them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_owner_reg <= ARB_NONE;
    end else begin
      rd_owner_reg <= next_rd_owner(a_gnt, a_we, b_gnt, b_we);
    end
  end

  // Memory output register already provides the one-cycle latency; data is shared, valids are not.
  assign a_rvalid = (rd_owner_reg == ARB_A);
  assign b_rvalid = (rd_owner_reg == ARB_B);
  assign a_rdata  = mem_rdata;
  assign b_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural synchronous-read memory.
// Read responses are scoreboarded: expected data is queued when a read grant is
// expected and compared by a monitor when the response cycle arrives.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_req, a_we, b_req, b_we;
  logic [7:0]  a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid, b_starved, mem_we;
  logic [15:0] a_rdata, b_rdata, mem_wdata, mem_rdata;
  logic [7:0]  mem_addr;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .b_starved(b_starved)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Initial memory image, used both by the memory model and the expectation shadow.
  function automatic logic [15:0] init_val(input logic [7:0] a);
    if (a == 8'h10) return 16'h1234;
    return {a ^ 8'hA5, a};
  endfunction

  // Behavioural D_memory: registered read, write at the clock edge.
  bit [15:0] mem [256];
  bit        mem_wr [256];
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr]    <= mem_wdata;
      mem_wr[mem_addr] <= 1'b1;
    end
    mem_rdata <= mem_wr[mem_addr] ? mem[mem_addr] : init_val(mem_addr);
  end

  typedef struct {
    logic        port_b;
    logic [15:0] data;
    int          cyc;
  } exp_t;
  exp_t        exp_q[$];
  logic [15:0] shadow [256];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic drive(input logic ar, input logic aw, input logic [7:0] aa, input logic [15:0] ad,
                       input logic br, input logic bw, input logic [7:0] ba, input logic [15:0] bd);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rd(input logic pb, input logic [7:0] addr);
    exp_t e;
    e.port_b = pb;
    e.data   = shadow[addr];
    e.cyc    = cyc;
    exp_q.push_back(e);
    $display("[%0t] expect %s read addr=%02h data=%04h", $time, pb ? "B" : "A", addr, shadow[addr]);
  endtask

  // Scoreboard consumer: every cycle, rvalids must match exactly the read granted last cycle.
  task automatic monitor_rd();
    exp_t        e;
    logic        ea, eb;
    logic [15:0] ed;
    forever begin
      @(negedge clk);
      ea = 1'b0; eb = 1'b0; ed = '0;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc - 1) begin
        e  = exp_q.pop_front();
        ea = !e.port_b;
        eb = e.port_b;
        ed = e.data;
      end
      n_checks++;
      if (a_rvalid !== ea || b_rvalid !== eb) begin
        n_fail++;
        $display("FAIL rvalid cyc=%0d: got a=%b b=%b, expected a=%b b=%b", cyc, a_rvalid, b_rvalid, ea, eb);
      end else if (ea || eb) begin
        n_checks++;
        if ((ea ? a_rdata : b_rdata) !== ed) begin
          n_fail++;
          $display("FAIL rdata_%s cyc=%0d: got %04h, expected %04h", ea ? "a" : "b", cyc, ea ? a_rdata : b_rdata, ed);
        end else begin
          $display("[%0t] resp %s data=%04h ok", $time, ea ? "A" : "B", ed);
        end
      end
    end
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 8'h10, 16'h0, 1'b1, 1'b0, 8'h11, 16'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (a_gnt !== 1'b1 || b_gnt !== 1'b0 || b_starved !== 1'b0 || a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state: got a_gnt=%b b_gnt=%b starved=%b rv=%b%b, expected 1 0 0 00",
                 a_gnt, b_gnt, b_starved, a_rvalid, b_rvalid);
      end else $display("[%0t] reset state ok", $time);
    end
    drive(1'b0, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0);
    @(posedge clk);
    #2 rst = 1'b1;
    tick();
  endtask

  task automatic test_idle();
    drive(1'b0, 1'b1, 8'h77, 16'hFFFF, 1'b0, 1'b1, 8'h11, 16'hAAAA);
    @(negedge clk);
    n_checks++;
    if (a_gnt !== 1'b0 || b_gnt !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 8'h77 || mem_wdata !== 16'h0) begin
      n_fail++;
      $display("FAIL idle_drive: got gnt=%b%b we=%b addr=%02h wdata=%04h, expected 00 0 77 0000",
               a_gnt, b_gnt, mem_we, mem_addr, mem_wdata);
    end else $display("[%0t] idle drive ok", $time);
    tick();
    drive(1'b0, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0);
  endtask

  task automatic test_a_read();
    drive(1'b1, 1'b0, 8'h10, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0);
    @(negedge clk);
    n_checks++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0 || mem_addr !== 8'h10 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL a_read_gnt: got gnt=%b%b addr=%02h we=%b, expected 10 10 0", a_gnt, b_gnt, mem_addr, mem_we);
    end
    push_rd(1'b0, 8'h10);
    tick();
    drive(1'b0, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0);
    tick();
    tick();
  endtask

  task automatic test_b_write_read();
    drive(1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 1'b1, 8'h20, 16'hBEEF);
    @(negedge clk);
    n_checks++;
    if (b_gnt !== 1'b1 || a_gnt !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 8'h20 || mem_wdata !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL b_write: got gnt=%b%b we=%b addr=%02h wdata=%04h, expected 01 1 20 beef",
               a_gnt, b_gnt, mem_we, mem_addr, mem_wdata);
    end
    shadow[8'h20] = 16'hBEEF;
    tick();
    drive(1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 1'b0, 8'h20, 16'h0);
    @(negedge clk);
    n_checks++;
    if (b_gnt !== 1'b1 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL b_read_gnt: got b_gnt=%b we=%b, expected 1 0", b_gnt, mem_we);
    end
    push_rd(1'b1, 8'h20);
    tick();
    drive(1'b0, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0);
    tick();
    tick();
  endtask

  task automatic test_pipelined();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 8'(i), 16'h0, 1'b0, 1'b0, 8'h00, 16'h0);
      @(negedge clk);
      n_checks++;
      if (a_gnt !== 1'b1 || mem_addr !== 8'(i)) begin
        n_fail++;
        $display("FAIL pipe_gnt%0d: got a_gnt=%b addr=%02h, expected 1 %02h", i, a_gnt, mem_addr, 8'(i));
      end
      push_rd(1'b0, 8'(i));
      tick();
    end
    drive(1'b0, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0);
    tick();
    tick();
  endtask

  task automatic test_owner_routing();
    drive(1'b1, 1'b0, 8'h05, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0);
    @(negedge clk);
    n_checks++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL route_a_gnt: got gnt=%b%b, expected 10", a_gnt, b_gnt);
    end
    push_rd(1'b0, 8'h05);
    tick();
    drive(1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 1'b0, 8'h06, 16'h0);
    @(negedge clk);
    n_checks++;
    if (a_gnt !== 1'b0 || b_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL route_b_gnt: got gnt=%b%b, expected 01", a_gnt, b_gnt);
    end
    push_rd(1'b1, 8'h06);
    tick();
    drive(1'b0, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0);
    tick();
    tick();
  endtask

  // Both ports hammer reads; addresses change every cycle while denied.
  task automatic test_starvation();
    int   w = 0;
    logic eb;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 8'h30 + 8'(i), 16'h0, 1'b1, 1'b0, 8'h80 + 8'(i), 16'h0);
      eb = (w == 4);
      @(negedge clk);
      n_checks++;
      if (a_gnt !== !eb || b_gnt !== eb || b_starved !== eb) begin
        n_fail++;
        $display("FAIL starve_step%0d: got a_gnt=%b b_gnt=%b starved=%b, expected %b %b %b",
                 i, a_gnt, b_gnt, b_starved, !eb, eb, eb);
      end else $display("[%0t] starve step %0d winner=%s", $time, i, eb ? "B" : "A");
      push_rd(eb, eb ? 8'h80 + 8'(i) : 8'h30 + 8'(i));
      w = eb ? 0 : ((w == 4) ? 4 : w + 1);
      tick();
    end
    drive(1'b0, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0);
    tick();
    tick();
  endtask

  // A writes continuously; B idles, then waits, drops out, and retries from a cleared counter.
  task automatic test_b_drop();
    logic [13:0] breq_pat = 14'b11111011000000;
    logic [13:0] bgnt_pat = 14'b10000000000000;
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, 1'b1, 8'h50 + 8'(i), 16'hC000 + 16'(i), breq_pat[i], 1'b0, 8'h50, 16'h0);
      @(negedge clk);
      n_checks++;
      if (b_gnt !== bgnt_pat[i] || a_gnt !== !bgnt_pat[i] || b_starved !== bgnt_pat[i]) begin
        n_fail++;
        $display("FAIL bdrop_step%0d: got a_gnt=%b b_gnt=%b starved=%b, expected %b %b %b",
                 i, a_gnt, b_gnt, b_starved, !bgnt_pat[i], bgnt_pat[i], bgnt_pat[i]);
      end else $display("[%0t] bdrop step %0d ok", $time, i);
      if (bgnt_pat[i]) push_rd(1'b1, 8'h50);
      else shadow[8'h50 + 8'(i)] = 16'hC000 + 16'(i);
      tick();
    end
    drive(1'b0, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0);
    tick();
    tick();
  endtask

  task automatic test_reset_mid_read();
    drive(1'b1, 1'b0, 8'h40, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0);
    @(negedge clk);
    n_checks++;
    if (a_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_gnt: got a_gnt=%b, expected 1", a_gnt);
    end
    push_rd(1'b0, 8'h40);
    tick();
    drive(1'b0, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0);
    n_checks++;
    if (a_rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre: got a_rvalid=%b, expected 1", a_rvalid);
    end
    rst = 1'b0;
    exp_q.delete();
    #1;
    n_checks++;
    if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_drop: got rvalid=%b%b, expected 00", a_rvalid, b_rvalid);
    end else $display("[%0t] rvalid dropped by reset", $time);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (a_gnt !== 1'b0 || b_gnt !== 1'b0 || a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_after%0d: got gnt=%b%b rv=%b%b, expected 00 00", i, a_gnt, b_gnt, a_rvalid, b_rvalid);
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = init_val(8'(i));
    drive(1'b0, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0);
    fork
      monitor_rd();
    join_none
    test_reset();
    test_idle();
    test_a_read();
    test_b_write_read();
    test_pipelined();
    test_owner_routing();
    test_starvation();
    test_b_drop();
    test_reset_mid_read();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending reads, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
